nibble_serial_compare: RTL and testbench



---
 rtl/nibble_serial_compare.sv | 86 ++++++++
 tb/tb_nibble_serial_compare.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/nibble_serial_compare.sv
// nibble_serial_compare: serial MSB-first nibble magnitude comparator with a 3-bit cascade input.
// Build option: define EARLY_EXIT_EN to finish on the first unequal nibble instead of stepping all nibbles.
// Ports:
//   iClk, iRst        clock, asynchronous active-high reset
//   iStart            start request, accepted only while idle
//   iData_a, iData_b  operands, 4*NIBBLES bits, captured on accepted start
//   iData             cascade {gt, eq, lt}, used when all nibbles are equal
//   oData             result {gt, lt, eq}, held until the next result
//   oValid            one-cycle strobe marking a new oData
//   oBusy             high while a compare is in progress
module nibble_serial_compare #(
    parameter int NIBBLES = 4
) (
    input  logic                 iClk,
    input  logic                 iRst,
    input  logic                 iStart,
    input  logic [4*NIBBLES-1:0] iData_a,
    input  logic [4*NIBBLES-1:0] iData_b,
    input  logic [2:0]           iData,
    output logic [2:0]           oData,
    output logic                 oValid,
    output logic                 oBusy
);
    localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    typedef enum logic {IDLE, RUN} state_t;
    state_t               state_q;
    logic [4*NIBBLES-1:0] a_q, b_q;
    logic [2:0]           casc_q, data_q, data_d;
    logic [IW-1:0]        idx_q;
    logic                 dec_q, gt_q, valid_q;
    logic [3:0]           nib_a, nib_b;
    logic                 dec_d, gt_d, done_d;

    always_comb begin
        nib_a  = a_q[{idx_q, 2'b00} +: 4];
        nib_b  = b_q[{idx_q, 2'b00} +: 4];
        // once decided, later nibbles cannot change the outcome
        dec_d  = dec_q | (nib_a != nib_b);
        gt_d   = dec_q ? gt_q : (nib_a > nib_b);
`ifdef EARLY_EXIT_EN
        done_d = (idx_q == '0) | dec_d;
`else
        done_d = (idx_q == '0);
`endif
        // undecided: cascade {gt,eq,lt} is reordered to the {gt,lt,eq} result layout
        data_d = dec_d ? (gt_d ? 3'b100 : 3'b010) : {casc_q[2], casc_q[0], casc_q[1]};
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            casc_q  <= '0;
            idx_q   <= '0;
            dec_q   <= 1'b0;
            gt_q    <= 1'b0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else if (state_q == IDLE) begin
            valid_q <= 1'b0;
            if (iStart) begin
                a_q     <= iData_a;
                b_q     <= iData_b;
                casc_q  <= iData;
                idx_q   <= IW'(NIBBLES - 1);
                dec_q   <= 1'b0;
                gt_q    <= 1'b0;
                state_q <= RUN;
            end
        end else begin
            valid_q <= done_d;
            dec_q   <= dec_d;
            gt_q    <= gt_d;
            idx_q   <= idx_q - IW'(1);
            if (done_d) begin
                state_q <= IDLE;
                data_q  <= data_d;
            end
        end
    end

    assign oData  = data_q;
    assign oValid = valid_q;
    assign oBusy  = (state_q == RUN);
endmodule

// File: tb/tb_nibble_serial_compare.sv
module tb_nibble_serial_compare;
    localparam int N = 4;
`ifdef EARLY_EXIT_EN
    localparam bit EE = 1'b1;
`else
    localparam bit EE = 1'b0;
`endif
    logic        clk = 1'b0, rst = 1'b1, start = 1'b0;
    logic [15:0] a = '0, b = '0;
    logic [2:0]  c = '0;
    logic [2:0]  oData;
    logic        oValid, oBusy;
    int          n_checks = 0, n_fail = 0;

    nibble_serial_compare #(.NIBBLES(N)) dut (
        .iClk(clk), .iRst(rst), .iStart(start), .iData_a(a), .iData_b(b),
        .iData(c), .oData(oData), .oValid(oValid), .oBusy(oBusy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Whole-operand unsigned compare; equal operands fall back to the cascade.
    function automatic logic [2:0] exp_res(input logic [15:0] x, input logic [15:0] y, input logic [2:0] cc);
        return (x > y) ? 3'b100 : (x < y) ? 3'b010 : {cc[2], cc[0], cc[1]};
    endfunction

    function automatic int lat_of(input logic [15:0] x, input logic [15:0] y);
        logic [15:0] tx, ty;
        if (!EE) return N;
        for (int i = N - 1; i >= 0; i--) begin
            tx = x >> (4 * i);
            ty = y >> (4 * i);
            if (tx[3:0] != ty[3:0]) return N - i;
        end
        return N;
    endfunction

    // Transaction-level model: busy countdown plus precomputed result.
    logic       m_busy = 1'b0, m_valid = 1'b0;
    logic [2:0] m_data = '0, m_res = '0;
    int         m_cnt = 0;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy = 1'b0; m_valid = 1'b0; m_data = '0; m_cnt = 0;
        end else begin
            m_valid = 1'b0;
            if (m_busy) begin
                m_cnt--;
                if (m_cnt == 0) begin
                    m_busy = 1'b0; m_valid = 1'b1; m_data = m_res;
                end
            end else if (start) begin
                m_busy = 1'b1;
                m_cnt  = lat_of(a, b);
                m_res  = exp_res(a, b, c);
            end
        end
    end

    logic prev_valid = 1'b0;
    always @(negedge clk) begin
        chk("cyc_data", oData, m_data);
        chk("cyc_valid", oValid, m_valid);
        chk("cyc_busy", oBusy, m_busy);
        chk("valid_twice", prev_valid & oValid, 0);
        prev_valid = oValid;
    end

    task automatic run(input logic [15:0] x, input logic [15:0] y, input logic [2:0] cc,
                       input logic [2:0] ed, input int el, input string nm);
        bit got = 1'b0;
        a = x; b = y; c = cc; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        for (int k = 1; k <= 40 && !got; k++) begin
            @(posedge clk); #1;
            if (oValid) begin
                got = 1'b1;
                chk({nm, "_data"}, oData, ed);
                chk({nm, "_lat"}, k, el);
            end
        end
        chk({nm, "_done"}, got, 1);
    endtask

    initial begin
        int cnt, last, pulses;
        logic [2:0] d;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_data", oData, 0);
        chk("rst_valid", oValid, 0);
        chk("rst_busy", oBusy, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        run(16'h8000, 16'h0001, 3'b000, 3'b100, EE ? 1 : 4, "msb_gt");
        run(16'h1234, 16'h1234, 3'b010, 3'b001, 4, "eq_casc_eq");
        run(16'h1234, 16'h1234, 3'b100, 3'b100, 4, "eq_casc_gt");
        run(16'h1234, 16'h1234, 3'b001, 3'b010, 4, "eq_casc_lt");
        run(16'h1234, 16'h1234, 3'b000, 3'b000, 4, "eq_casc_none");
        run(16'h1234, 16'h1234, 3'b111, 3'b111, 4, "eq_casc_all");
        run(16'h1230, 16'h1234, 3'b000, 3'b010, 4, "lsb_lt");
        run(16'h0200, 16'h0100, 3'b000, 3'b100, EE ? 2 : 4, "nib2_gt");

        // Start requests and operand changes while busy must be ignored.
        a = 16'h1234; b = 16'h1230; c = 3'b000; start = 1'b1;
        @(posedge clk); #1 a = 16'h0000; b = 16'hffff;
        @(posedge clk); #1 start = 1'b0; a = 16'hffff; b = 16'h0000;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        cnt = 0; d = '0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (oValid) begin cnt++; d = oData; end
        end
        chk("busy_ign_count", cnt, 1);
        chk("busy_ign_data", d, 3'b100);

        // Asynchronous reset mid-compare.
        a = 16'h1234; b = 16'h1230; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        @(posedge clk);
        @(posedge clk); #2 rst = 1'b1;
        #1;
        chk("arst_data", oData, 0);
        chk("arst_busy", oBusy, 0);
        chk("arst_valid", oValid, 0);
        @(negedge clk); #1 rst = 1'b0;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (oValid) cnt++;
        end
        chk("arst_no_valid", cnt, 0);
        run(16'h0001, 16'h0002, 3'b000, 3'b010, 4, "post_rst");

        // Back-to-back with start held high and operands alternating every cycle.
        last = -1; pulses = 0;
        a = 16'h1234; b = 16'h1230; start = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #1;
            if (oValid) begin
                if (last >= 0) chk("b2b_gap", i - last, 5);
                last = i; pulses++;
            end
            {a, b} = {b, a};
        end
        start = 1'b0;
        chk("b2b_pulses", pulses >= 9, 1);
        repeat (8) @(posedge clk);
        #1 chk("drain_busy", oBusy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
